// File: rtl/pipe4_pkg.sv
// pipe4_pkg: ALU function codes and the S1 stage-register layout shared by pipe4_alu_param.
// Stage fields are sized for the widest supported build (DATA_W <= 32, NREG <= 256, MEM_DEPTH <= 65536).
package pipe4_pkg;

    localparam int DATA_MAX = 32;
    localparam int RA_MAX   = 8;
    localparam int MA_MAX   = 16;

    typedef enum logic [3:0] {
        F_ADD  = 4'd0,
        F_SUB  = 4'd1,
        F_MUL  = 4'd2,
        F_SELA = 4'd3,
        F_SELB = 4'd4,
        F_AND  = 4'd5,
        F_OR   = 4'd6,
        F_XOR  = 4'd7,
        F_NEGA = 4'd8,
        F_NEGB = 4'd9,
        F_SRA  = 4'd10,
        F_SLA  = 4'd11
    } alu_func_t;

    typedef struct packed {
        logic                valid;
        logic [RA_MAX-1:0]   rd;
        logic [MA_MAX-1:0]   addr;
        alu_func_t           func;
        logic [DATA_MAX-1:0] a;
        logic [DATA_MAX-1:0] b;
    } stage_t;

endpackage

// File: rtl/pipe4_alu_param_alu.sv
// pipe4_alu: purely combinational ALU, y = func(a, b), all arithmetic wraps modulo 2^DATA_W.
module pipe4_alu
    import pipe4_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        func,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        case (func)
            F_ADD:   y = a + b;
            F_SUB:   y = a - b;
            F_MUL:   y = a * b;   // context width keeps only the low DATA_W product bits
            F_SELA:  y = a;
            F_SELB:  y = b;
            F_AND:   y = a & b;
            F_OR:    y = a | b;
            F_XOR:   y = a ^ b;
            F_NEGA:  y = -a;
            F_NEGB:  y = -b;
            F_SRA:   y = a >> 1;
            F_SLA:   y = a << 1;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/pipe4_alu_param.sv
// pipe4_alu_param: 4-stage register-read / ALU / write-back / store pipeline with RAW hazard handling.
// Build option: define FORWARD_EN for full operand bypass; otherwise hazards stall the input.
module pipe4_alu_param
    import pipe4_pkg::*;
#(
    parameter  int DATA_W    = 16,
    parameter  int NREG      = 16,
    parameter  int MEM_DEPTH = 256,
    localparam int RA_W      = $clog2(NREG),
    localparam int MA_W      = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RA_W-1:0]   rs1,
    input  logic [RA_W-1:0]   rs2,
    input  logic [RA_W-1:0]   rd,
    input  logic [3:0]        func,
    input  logic [MA_W-1:0]   addr,
    output logic [DATA_W-1:0] z,
    output logic              z_valid
);

    logic [DATA_W-1:0] regbank [NREG];
    logic [DATA_W-1:0] mem     [MEM_DEPTH];

    stage_t            s1_q;
    logic              s2_valid;
    logic [RA_W-1:0]   s2_rd;
    logic [MA_W-1:0]   s2_addr;
    logic              s3_valid;
    logic [MA_W-1:0]   s3_addr;
    logic [DATA_W-1:0] s3_data;

    logic [DATA_W-1:0] s1_a, s1_b, alu_y;
    logic [DATA_W-1:0] op_a, op_b;
    logic              a_s1, a_s2, b_s1, b_s2;
    logic              accept;
    logic              unused_stage;

    assign s1_a = s1_q.a[DATA_W-1:0];
    assign s1_b = s1_q.b[DATA_W-1:0];

    // Upper stage-field bits exist only for wider builds.
    assign unused_stage = ^s1_q;

    pipe4_alu #(.DATA_W(DATA_W)) u_alu (
        .a    (s1_a),
        .b    (s1_b),
        .func (s1_q.func),
        .y    (alu_y)
    );

    // A write is pending while its producer sits in S1 (not yet computed) or S2 (in z, not yet in regbank).
    assign a_s1 = s1_q.valid && (s1_q.rd[RA_W-1:0] == rs1);
    assign a_s2 = s2_valid   && (s2_rd == rs1);
    assign b_s1 = s1_q.valid && (s1_q.rd[RA_W-1:0] == rs2);
    assign b_s2 = s2_valid   && (s2_rd == rs2);

    // Handshake: an instruction is taken on any rising edge where in_valid && in_ready;
    // in_ready depends only on rs1/rs2 and the S1/S2 state, never on in_valid.
`ifdef FORWARD_EN
    always_comb begin
        op_a = regbank[rs1];
        op_b = regbank[rs2];
        // S1 is the younger producer, so it takes priority over z.
        if (a_s1)      op_a = alu_y;
        else if (a_s2) op_a = z;
        if (b_s1)      op_b = alu_y;
        else if (b_s2) op_b = z;
    end
    assign in_ready = 1'b1;
`else
    assign op_a     = regbank[rs1];
    assign op_b     = regbank[rs2];
    assign in_ready = !(a_s1 || a_s2 || b_s1 || b_s2);
`endif

    assign accept  = in_valid && in_ready;
    assign z_valid = s2_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= '0;
            s2_valid <= 1'b0;
            s2_rd    <= '0;
            s2_addr  <= '0;
            z        <= '0;
            s3_valid <= 1'b0;
            s3_addr  <= '0;
            s3_data  <= '0;
        end else begin
            s1_q.valid <= accept;
            if (accept) begin
                s1_q.rd   <= RA_MAX'(rd);
                s1_q.addr <= MA_MAX'(addr);
                s1_q.func <= alu_func_t'(func);
                s1_q.a    <= DATA_MAX'(op_a);
                s1_q.b    <= DATA_MAX'(op_b);
            end
            s2_valid <= s1_q.valid;
            if (s1_q.valid) begin
                z       <= alu_y;
                s2_rd   <= s1_q.rd[RA_W-1:0];
                s2_addr <= s1_q.addr[MA_W-1:0];
            end
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_addr <= s2_addr;
                s3_data <= z;
            end
        end
    end

    // Storage is not reset; a reset edge only suppresses the write scheduled for it.
    always_ff @(posedge clk) begin
        if (!rst && s2_valid) regbank[s2_rd] <= z;
        if (!rst && s3_valid) mem[s3_addr]   <= s3_data;
    end

endmodule

// File: tb/tb_pipe4_alu_param.sv
// tb_pipe4_alu_param: randomized and directed stimulus against an in-order architectural model of pipe4_alu_param.
module tb_pipe4_alu_param;

    localparam int DW   = 8;
    localparam int NREG = 16;
    localparam int MD   = 256;
    localparam int RA_W = 4;
    localparam int MA_W = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [RA_W-1:0] rs1, rs2, rd;
    logic [3:0]      func;
    logic [MA_W-1:0] addr;
    logic [DW-1:0]   z;
    logic            z_valid;

    pipe4_alu_param #(.DATA_W(DW), .NREG(NREG), .MEM_DEPTH(MD)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .func     (func),
        .addr     (addr),
        .z        (z),
        .z_valid  (z_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    logic [DW-1:0] mdl_reg[NREG];
    logic [DW-1:0] mdl_mem[MD];
    int            last_acc[NREG];

`ifdef FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // ---------------- scoreboard: every z_valid must match the oldest expected result and cycle
    logic [DW-1:0] sb_e;
    int            sb_c;
    always @(negedge clk) begin
        if (z_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL z_unexpected: got z=%0d with no instruction outstanding (cycle %0d)", z, cyc);
            end else begin
                sb_e = exp_q.pop_front();
                sb_c = exp_cyc_q.pop_front();
                if (z !== sb_e || cyc != sb_c)
                    $display("FAIL z_stream: got z=%0d at cycle %0d, expected z=%0d at cycle %0d", z, cyc, sb_e, sb_c);
                else
                    n_pass++;
            end
        end
    end

    // ---------------- reference model
    function automatic logic [DW-1:0] ref_alu(input int a, input int b, input int f);
        int m;
        int r;
        m = 1 << DW;
        case (f)
            0:  r = a + b;
            1:  r = a - b;
            2:  r = a * b;
            3:  r = a;
            4:  r = b;
            5:  r = a & b;
            6:  r = a | b;
            7:  r = a ^ b;
            8:  r = -a;
            9:  r = -b;
            10: r = a / 2;
            11: r = a * 2;
            default: r = 0;
        endcase
        return DW'(((r % m) + m) % m);
    endfunction

    function automatic int mem_diffs();
        int n = 0;
        for (int i = 0; i < MD; i++) if (dut.mem[i] !== mdl_mem[i]) n++;
        return n;
    endfunction

    function automatic int reg_diffs();
        int n = 0;
        for (int i = 0; i < NREG; i++) if (dut.regbank[i] !== mdl_reg[i]) n++;
        return n;
    endfunction

    // ---------------- driver tasks (always entered and left at posedge + 1)
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preload_regs();
        for (int k = 0; k < NREG; k++) begin
            dut.regbank[k] = DW'(k);
            mdl_reg[k]     = DW'(k);
            last_acc[k]    = -100;
        end
    endtask

    task automatic preload_mem();
        for (int i = 0; i < MD; i++) begin
            dut.mem[i] = DW'(i ^ 8'hA5);
            mdl_mem[i] = DW'(i ^ 8'hA5);
        end
    endtask

    // Offers one instruction until taken. A producer accepted at cycle p blocks a reader
    // until cycle p+3 when there is no bypass.
    task automatic issue(input int r1, input int r2, input int d, input int f, input int ad,
                         input bit drop, output int stalls, output int exp_stalls);
        int            acc;
        int            t0;
        bit            done;
        logic [DW-1:0] res;
        in_valid = 1'b1;
        rs1 = RA_W'(r1); rs2 = RA_W'(r2); rd = RA_W'(d);
        func = 4'(f); addr = MA_W'(ad);
        stalls = 0; done = 1'b0; acc = 0; t0 = -1;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge clk);
            if (t0 < 0) t0 = cyc;
            if (in_ready) begin
                acc  = cyc;
                done = 1'b1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        exp_stalls = 0;
        if (!FWD) begin
            if (last_acc[r1] + 3 - t0 > exp_stalls) exp_stalls = last_acc[r1] + 3 - t0;
            if (last_acc[r2] + 3 - t0 > exp_stalls) exp_stalls = last_acc[r2] + 3 - t0;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL issue_timeout: in_ready stayed 0 for 8 cycles, expected acceptance within 2");
        end else if (!drop) begin
            res = ref_alu(int'(mdl_reg[r1]), int'(mdl_reg[r2]), f);
            exp_q.push_back(res);
            exp_cyc_q.push_back(acc + 2);
            mdl_reg[d]  = res;
            mdl_mem[ad] = res;
            last_acc[d] = acc;
        end
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (z !== '0) $display("FAIL reset_z: got %0d expected 0", z); else n_pass++;
        n_checks++;
        if (z_valid !== 1'b0) $display("FAIL reset_z_valid: got %0b expected 0", z_valid); else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b expected 1", in_ready); else n_pass++;
        idle(4);
        n_checks++;
        if (mem_diffs() != 0) $display("FAIL reset_mem: got %0d changed words expected 0", mem_diffs()); else n_pass++;
    endtask

    task automatic test_independent();
        int s, es, tot;
        preload_regs();
        tot = 0;
        issue(3, 5, 10, 0, 125, 1'b0, s, es); tot += s;
        issue(3, 8, 12, 2, 126, 1'b0, s, es); tot += s;
        issue(7, 0, 13, 11, 127, 1'b0, s, es); tot += s;
        idle(6);
        n_checks++;
        if (tot != 0) $display("FAIL indep_stalls: got %0d expected 0", tot); else n_pass++;
        n_checks++;
        if (dut.mem[125] !== 8'd8) $display("FAIL indep_mem125: got %0d expected 8", dut.mem[125]); else n_pass++;
        n_checks++;
        if (dut.mem[126] !== 8'd24) $display("FAIL indep_mem126: got %0d expected 24", dut.mem[126]); else n_pass++;
        n_checks++;
        if (dut.mem[127] !== 8'd14) $display("FAIL indep_mem127: got %0d expected 14", dut.mem[127]); else n_pass++;
        n_checks++;
        if (dut.regbank[10] !== 8'd8) $display("FAIL indep_reg10: got %0d expected 8", dut.regbank[10]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int s, es;
        preload_regs();
        issue(3, 5, 10, 0, 124, 1'b0, s, es);
        issue(10, 5, 14, 1, 128, 1'b0, s, es);
        idle(6);
        n_checks++;
        if (s != (FWD ? 0 : 2)) $display("FAIL b2b_stalls: got %0d expected %0d", s, FWD ? 0 : 2); else n_pass++;
        n_checks++;
        if (dut.mem[128] !== 8'd3) $display("FAIL b2b_mem128: got %0d expected 3", dut.mem[128]); else n_pass++;
        n_checks++;
        if (dut.regbank[14] !== 8'd3) $display("FAIL b2b_reg14: got %0d expected 3", dut.regbank[14]); else n_pass++;
    endtask

    task automatic test_distance2();
        int s, es;
        preload_regs();
        issue(3, 5, 10, 0, 124, 1'b0, s, es);
        issue(1, 2, 11, 7, 123, 1'b0, s, es);
        issue(10, 5, 15, 1, 129, 1'b0, s, es);
        idle(6);
        n_checks++;
        if (s != (FWD ? 0 : 1)) $display("FAIL dist2_stalls: got %0d expected %0d", s, FWD ? 0 : 1); else n_pass++;
        n_checks++;
        if (dut.mem[129] !== 8'd3) $display("FAIL dist2_mem129: got %0d expected 3", dut.mem[129]); else n_pass++;
    endtask

    task automatic test_edge_funcs();
        int s, es;
        preload_regs();
        issue(15, 15, 14, 2, 131, 1'b0, s, es);
        issue(0, 1, 2, 1, 132, 1'b0, s, es);
        issue(4, 5, 3, 13, 133, 1'b0, s, es);
        idle(6);
        n_checks++;
        if (dut.mem[131] !== 8'd225) $display("FAIL edge_mul: got %0d expected 225", dut.mem[131]); else n_pass++;
        n_checks++;
        if (dut.mem[132] !== 8'd255) $display("FAIL edge_sub_wrap: got %0d expected 255", dut.mem[132]); else n_pass++;
        n_checks++;
        if (dut.mem[133] !== 8'd0) $display("FAIL edge_func13: got %0d expected 0", dut.mem[133]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int s, es;
        bit seen_zv;
        preload_regs();
        issue(3, 5, 10, 0, 130, 1'b1, s, es);
        rst = 1'b1;
        seen_zv = 1'b0;
        @(negedge clk);
        if (z_valid) seen_zv = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (z_valid) seen_zv = 1'b1;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (seen_zv) $display("FAIL rstmid_z_valid: got z_valid=1 expected 0 throughout"); else n_pass++;
        n_checks++;
        if (dut.regbank[10] !== 8'd10) $display("FAIL rstmid_reg10: got %0d expected 10", dut.regbank[10]); else n_pass++;
        n_checks++;
        if (dut.mem[130] !== mdl_mem[130]) $display("FAIL rstmid_mem130: got %0d expected %0d", dut.mem[130], mdl_mem[130]); else n_pass++;
    endtask

    task automatic test_random();
        int s, es, bad_stall;
        preload_regs();
        bad_stall = 0;
        for (int n = 0; n < 80; n++) begin
            issue($urandom_range(0, NREG-1), $urandom_range(0, NREG-1), $urandom_range(0, NREG-1),
                  $urandom_range(0, 15), $urandom_range(0, MD-1), 1'b0, s, es);
            if (s != es) bad_stall++;
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(6);
        n_checks++;
        if (bad_stall != 0) $display("FAIL rand_stalls: got %0d mispredicted stall counts expected 0", bad_stall); else n_pass++;
        n_checks++;
        if (reg_diffs() != 0) $display("FAIL rand_regbank: got %0d differing registers expected 0", reg_diffs()); else n_pass++;
        n_checks++;
        if (mem_diffs() != 0) $display("FAIL rand_mem: got %0d differing words expected 0", mem_diffs()); else n_pass++;
    endtask

    // ---------------- sequence
    initial begin
        rst = 1'b1; in_valid = 1'b0;
        rs1 = '0; rs2 = '0; rd = '0; func = '0; addr = '0;
        idle(2);
        rst = 1'b0;
        preload_mem();
        preload_regs();
        test_reset();
        test_independent();
        test_back_to_back();
        test_distance2();
        test_edge_funcs();
        test_reset_mid();
        test_random();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL drain: got %0d results never produced expected 0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
